// File: rtl/cache_parameters_pkg.sv
// Shared widths, operation codes and handshake structs for the cache and
// the two-port arbiter that sits in front of its processor-side port.
package cache_parameters;

  localparam int ADDRESS_BUSWIDTH = 32;
  localparam int DATA_BUSWIDTH    = 32;
  localparam int ARB_NPORTS       = 2;

  // Processor-side operation codes
  localparam logic [1:0] OPNONE  = 2'd0;
  localparam logic [1:0] OPREAD  = 2'd1;
  localparam logic [1:0] OPWRITE = 2'd2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} type_arb_state_e;

  // Processor -> cache request. Handshake: the cache takes a request while
  // valid=1 and answers with cache2processor.valid=1 for exactly one cycle;
  // the requester holds operation/address/data stable until that answer.
  typedef struct packed {
    logic [1:0]                  operation;
    logic                        valid;
    logic                        ready;
    logic [ADDRESS_BUSWIDTH-1:0] address;
    logic [DATA_BUSWIDTH-1:0]    data;
  } type_processor2cache_s;

  // Cache -> processor response; ready=1 means a new request may be issued.
  typedef struct packed {
    logic                     valid;
    logic                     ready;
    logic [DATA_BUSWIDTH-1:0] data;
  } type_cache2processor_s;

  // One requester's transaction, used for the per-port view and the latch.
  typedef struct packed {
    logic [1:0]                  op;
    logic [ADDRESS_BUSWIDTH-1:0] address;
    logic [DATA_BUSWIDTH-1:0]    data;
  } type_arb_req_s;

  // One-hot vector selecting a single arbiter port
  function automatic logic [ARB_NPORTS-1:0] port_onehot(input logic idx);
    logic [ARB_NPORTS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the
// port named by prio wins. Purely combinational.
module rr_picker
  import cache_parameters::*;
(
  input  logic [ARB_NPORTS-1:0] req,
  input  logic                  prio,
  output logic [ARB_NPORTS-1:0] grant,
  output logic                  idx
);

  // Resolve the winner index, then expand it to a one-hot grant
  always_comb begin
    idx   = 1'b0;
    grant = '0;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = prio;
      default: idx = 1'b0;
    endcase
    if (|req) begin
      grant = port_onehot(idx);
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the cache's single processor-side port between instruction fetch
// (port 0) and the load/store unit (port 1). One transaction at a time:
// IDLE grants a port and latches its payload, BUSY presents the latched
// payload to the cache until it answers or the timeout counter expires.
// Every transaction ends with one IDLE cycle so a requester that saw its
// resp_valid/resp_err pulse can drop req_valid before the next grant.
module cache_arbiter
  import cache_parameters::*;
#(
  parameter int ADDRESS_BUSWIDTH = cache_parameters::ADDRESS_BUSWIDTH,
  parameter int DATA_BUSWIDTH    = cache_parameters::DATA_BUSWIDTH,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [ARB_NPORTS-1:0]                        req_valid,
  input  logic [ARB_NPORTS-1:0][1:0]                   req_op,
  input  logic [ARB_NPORTS-1:0][ADDRESS_BUSWIDTH-1:0]  req_addr,
  input  logic [ARB_NPORTS-1:0][DATA_BUSWIDTH-1:0]     req_data,
  output logic [ARB_NPORTS-1:0]                        resp_valid,
  output logic [ARB_NPORTS-1:0]                        resp_err,
  output logic [DATA_BUSWIDTH-1:0]                     resp_data,
  output type_processor2cache_s                        processor2cache,
  input  type_cache2processor_s                        cache2processor,
  output logic                                         dbg_state,
  output logic                                         dbg_prio
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  type_arb_state_e       state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  winner_q, winner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  type_arb_req_s         lat_q, lat_d;

  logic [ARB_NPORTS-1:0] eligible;
  logic [ARB_NPORTS-1:0] pick_grant;
  logic                  pick_idx;
  logic                  resp_hit;
  logic                  err_hit;

  // A port competes only when it is valid and asks for a real operation
  always_comb begin
    eligible = '0;
    for (int i = 0; i < ARB_NPORTS; i++) begin
      eligible[i] = req_valid[i] && (req_op[i] != OPNONE);
    end
  end

  rr_picker u_picker (
    .req   (eligible),
    .prio  (prio_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Next-state logic: grant/latch in IDLE, complete or time out in BUSY
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    resp_hit = 1'b0;
    err_hit  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (cache2processor.ready && (|pick_grant)) begin
          lat_d.op      = req_op[pick_idx];
          lat_d.address = req_addr[pick_idx];
          lat_d.data    = req_data[pick_idx];
          winner_d      = pick_idx;
          cnt_d         = '0;
          state_d       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A response on the last allowed cycle still wins over the timeout
        if (cache2processor.valid) begin
          resp_hit = 1'b1;
          prio_d   = ~winner_q;
          state_d  = ARB_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          err_hit  = 1'b1;
          prio_d   = ~winner_q;
          state_d  = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      prio_q   <= 1'b0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
    end
  end

  // Cache-side request: driven from the latch only while BUSY so the cache
  // never sees the requester's live (possibly changing) payload
  always_comb begin
    processor2cache       = '0;
    processor2cache.ready = 1'b1;
    if (state_q == ARB_BUSY) begin
      processor2cache.valid     = 1'b1;
      processor2cache.operation = lat_q.op;
      processor2cache.address   = lat_q.address;
      processor2cache.data      = lat_q.data;
    end
  end

  // Requester-side pulses go to the winner only; suppressed while reset is
  // asserted so an aborted transaction never completes
  always_comb begin
    resp_valid = '0;
    resp_err   = '0;
    resp_data  = '0;
    if (!reset) begin
      if (resp_hit) begin
        resp_valid = port_onehot(winner_q);
        resp_data  = cache2processor.data;
      end
      if (err_hit) begin
        resp_err = port_onehot(winner_q);
      end
    end
  end

  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  import cache_parameters::*;

  localparam int   T       = 8;
  localparam logic ST_IDLE = 1'b0;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid;
  logic [1:0][1:0]       req_op;
  logic [1:0][31:0]      req_addr;
  logic [1:0][31:0]      req_data;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_err;
  logic [31:0]           resp_data;
  type_processor2cache_s p2c;
  type_cache2processor_s c2p;
  logic                  dbg_state;
  logic                  dbg_prio;

  int n_vec = 0;
  int n_err = 0;

  // Model: round-robin pointer, flips to the other port after every finish
  logic m_prio;
  // Scoreboard of expected grant order
  logic [0:0] exp_q[$];

  cache_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .resp_valid      (resp_valid),
    .resp_err        (resp_err),
    .resp_data       (resp_data),
    .processor2cache (p2c),
    .cache2processor (c2p),
    .dbg_state       (dbg_state),
    .dbg_prio        (dbg_prio)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    c2p       = '0;
    c2p.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_prio = 1'b0;
    #2;
  endtask

  // Runs one transaction from an IDLE cycle whose requests are already
  // driven. lat = BUSY cycles before the cache answers (>= T never answers).
  task automatic serve(input int lat, input logic [31:0] rdata, input bit mutate,
                       input logic [31:0] new_addr, input string tag, output logic won);
    logic [1:0]  elig;
    logic        w;
    logic [1:0]  exp_oh;
    logic [1:0]  e_op;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    bit          done;
    for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (req_op[i] != OPNONE);
    w      = (elig == 2'b11) ? m_prio : elig[1];
    exp_oh = 2'b01 << w;
    e_op   = req_op[w];
    e_addr = req_addr[w];
    e_data = req_data[w];
    done   = 1'b0;
    won    = 1'b0;
    for (int k = 1; k <= T && !done; k++) begin
      tick();
      c2p.valid = (k == lat + 1);
      c2p.data  = (k == lat + 1) ? rdata : $urandom;
      if (mutate && k == 2) begin
        req_addr[w] = new_addr;
        req_data[w] = ~req_data[w];
      end
      #2;
      n_vec++;
      if ({p2c.valid, p2c.operation, p2c.address, p2c.data} !== {1'b1, e_op, e_addr, e_data}) begin
        n_err++;
        $display("FAIL %s busy%0d cache_req: got v=%b op=%0d a=%h d=%h, want v=1 op=%0d a=%h d=%h",
                 tag, k, p2c.valid, p2c.operation, p2c.address, p2c.data, e_op, e_addr, e_data);
      end
      n_vec++;
      if (k == lat + 1) begin
        done = 1'b1;
        if ({resp_valid, resp_err, resp_data} !== {exp_oh, 2'b00, rdata}) begin
          n_err++;
          $display("FAIL %s busy%0d response: got rv=%b re=%b rd=%h, want rv=%b re=00 rd=%h",
                   tag, k, resp_valid, resp_err, resp_data, exp_oh, rdata);
        end
      end else if (k == T) begin
        done = 1'b1;
        if ({resp_valid, resp_err} !== {2'b00, exp_oh}) begin
          n_err++;
          $display("FAIL %s busy%0d timeout: got rv=%b re=%b, want rv=00 re=%b",
                   tag, k, resp_valid, resp_err, exp_oh);
        end
      end else begin
        if ({resp_valid, resp_err} !== 4'b0000) begin
          n_err++;
          $display("FAIL %s busy%0d quiet: got rv=%b re=%b, want rv=00 re=00",
                   tag, k, resp_valid, resp_err);
        end
      end
      if (done) won = resp_valid[1] | resp_err[1];
    end
    // Mandatory IDLE gap; the winner withdraws its request here
    tick();
    c2p.valid    = 1'b0;
    req_valid[w] = 1'b0;
    m_prio       = ~w;
    #2;
    n_vec++;
    if ({p2c.valid, dbg_state, dbg_prio} !== {1'b0, ST_IDLE, m_prio}) begin
      n_err++;
      $display("FAIL %s idle_gap: got v=%b st=%b prio=%b, want v=0 st=%b prio=%b",
               tag, p2c.valid, dbg_state, dbg_prio, ST_IDLE, m_prio);
    end
  endtask

  task automatic idle_cycle(input string tag);
    tick();
    #2;
    n_vec++;
    if ({p2c.valid, dbg_state} !== {1'b0, ST_IDLE}) begin
      n_err++;
      $display("FAIL %s stay_idle: got v=%b st=%b, want v=0 st=%b", tag, p2c.valid, dbg_state, ST_IDLE);
    end
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_addr[p]  = a;
    req_data[p]  = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({resp_valid, resp_err, resp_data, p2c.valid, p2c.operation, p2c.address, p2c.data} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got rv=%b re=%b rd=%h v=%b op=%0d a=%h d=%h, want all zero",
               resp_valid, resp_err, resp_data, p2c.valid, p2c.operation, p2c.address, p2c.data);
    end
    n_vec++;
    if ({dbg_state, dbg_prio} !== {ST_IDLE, 1'b0}) begin
      n_err++;
      $display("FAIL reset state: got st=%b prio=%b, want st=0 prio=0", dbg_state, dbg_prio);
    end
  endtask

  task automatic test_single_read();
    logic won;
    set_port(0, OPREAD, 32'h0000_0010, 32'h0);
    serve(3, 32'h2021_EE83, 1'b0, 32'h0, "single_read", won);
  endtask

  task automatic test_back_to_back();
    logic won;
    logic [0:0] e;
    apply_reset();
    set_port(0, OPWRITE, 32'h0000_0001, 32'hDEAD_BEEF);
    set_port(1, OPREAD,  32'h0000_0040, 32'h0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int r = 0; r < 4; r++) exp_q.push_back(1'(r % 2));
    for (int r = 0; r < 6; r++) begin
      if (r >= 2) req_valid = 2'b11;
      serve($urandom_range(0, 4), $urandom, 1'b0, 32'h0, "back_to_back", won);
      e = exp_q.pop_front();
      n_vec++;
      if (won !== e) begin
        n_err++;
        $display("FAIL back_to_back grant%0d: got port %0d, want port %0d", r, won, e);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_payload_stability();
    logic won;
    set_port(1, OPREAD, 32'h0000_0080, 32'h0);
    serve(5, 32'h1234_5678, 1'b1, 32'h0000_00C0, "payload_stable", won);
  endtask

  task automatic test_timeout();
    logic won;
    set_port(1, OPREAD, 32'h0000_0100, 32'h0);
    serve(1000, 32'h0, 1'b0, 32'h0, "timeout", won);
  endtask

  task automatic test_reset_mid_busy();
    logic won;
    set_port(0, OPREAD, 32'h0000_0200, 32'h0);
    tick();
    #2;
    n_vec++;
    if (p2c.valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy enter: got v=%b, want v=1", p2c.valid);
    end
    tick();
    reset = 1'b1;
    #2;
    n_vec++;
    if ({resp_valid, resp_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_busy during: got rv=%b re=%b, want 00 00", resp_valid, resp_err);
    end
    tick();
    reset     = 1'b0;
    req_valid = 2'b00;
    m_prio    = 1'b0;
    set_port(1, OPREAD, 32'h0000_0300, 32'h0);
    #2;
    n_vec++;
    if ({resp_valid, resp_err, resp_data, p2c.valid, p2c.operation, p2c.address, p2c.data,
         dbg_state, dbg_prio} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_busy after: got rv=%b re=%b v=%b op=%0d a=%h st=%b prio=%b, want all zero",
               resp_valid, resp_err, p2c.valid, p2c.operation, p2c.address, dbg_state, dbg_prio);
    end
    serve(2, 32'hCAFE_0001, 1'b0, 32'h0, "reset_mid_busy", won);
    n_vec++;
    if (won !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy grant: got port %0d, want port 1", won);
    end
    req_valid = '0;
  endtask

  task automatic test_ready_low();
    logic won;
    c2p.ready = 1'b0;
    set_port(0, OPWRITE, 32'h0000_0500, $urandom);
    for (int i = 0; i < 3; i++) idle_cycle("ready_low");
    c2p.ready = 1'b1;
    serve(1, 32'h0, 1'b0, 32'h0, "ready_rise", won);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic won;
    logic [1:0] elig;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req_valid[p] && req_op[p] != OPNONE)) begin
          req_valid[p] = ($urandom_range(0, 2) != 0);
          req_op[p]    = 2'($urandom_range(0, 2));
          req_addr[p]  = $urandom;
          req_data[p]  = $urandom;
        end
      end
      for (int p = 0; p < 2; p++) elig[p] = req_valid[p] && (req_op[p] != OPNONE);
      if (elig != 2'b00)
        serve($urandom_range(0, 9), $urandom, ($urandom_range(0, 3) == 0), $urandom, "random", won);
      else
        idle_cycle("random");
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) elig[p] = req_valid[p] && (req_op[p] != OPNONE);
      if (elig != 2'b00) serve($urandom_range(0, 3), $urandom, 1'b0, 32'h0, "drain", won);
    end
    req_valid = '0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_payload_stability();
    test_timeout();
    test_reset_mid_busy();
    test_ready_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single processor-side port of `cache` between two requesters (port 0: instruction fetch, port 1: load/store unit). It accepts one transaction at a time, picks the winner round-robin, and presents it to the cache using the `type_processor2cache_s` valid/hold handshake. It returns the cache response to the winning requester only, and aborts with an error pulse if the cache does not respond within a bounded number of cycles.

## Interface
Parameters:
- `ADDRESS_BUSWIDTH`, 32, address width (from `cache_parameters`)
- `DATA_BUSWIDTH`, 32, data width (from `cache_parameters`)
- `TIMEOUT_CYCLES`, 64, maximum BUSY cycles before abort; ≥2

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-port request valid; requester holds it and its payload stable until its `resp_valid` bit is seen
- `req_op`  in  2×2  per-port operation (`OPNONE`/`OPREAD`/`OPWRITE`)
- `req_addr`  in  2×ADDRESS_BUSWIDTH  per-port address
- `req_data`  in  2×DATA_BUSWIDTH  per-port write data
- `resp_valid`  out  2  one-hot, one-cycle completion pulse to the winner
- `resp_err`  out  2  one-hot, one-cycle timeout-abort pulse to the winner
- `resp_data`  out  DATA_BUSWIDTH  read data; valid only with `resp_valid`
- `processor2cache`  out  `type_processor2cache_s`  request to cache; `.ready` is tied to 1
- `cache2processor`  in  `type_cache2processor_s`  response from cache

## Operation
- States: IDLE, BUSY.
- IDLE:
  - `processor2cache.valid`=0 and `.operation`=OPNONE.
  - When `cache2processor.ready`=1 and any valid port has `req_op`≠OPNONE, grant one port:
    - If only one port is valid, that port wins.
    - If both are valid, the port indicated by `prio` wins.
  - On grant: latch the winner's op/addr/data into registers, store the winner index, clear the timeout counter, go to BUSY.
  - A valid port with `req_op`=OPNONE is ignored and never granted.
- BUSY:
  - `processor2cache.valid`=1; `.operation`/`.address`/`.data` come from the latched registers, so they stay stable even if the requester changes them.
  - If `cache2processor.valid`=1:
    - `resp_valid[winner]`=1 combinationally in the same cycle; `resp_data` = `cache2processor.data`.
    - `prio` ← ~winner; next state IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES−1 with no response:
    - `resp_err[winner]`=1 for that cycle; `prio` ← ~winner; next state IDLE.
  - A response and a timeout in the same cycle count as a response; no error is raised.
- The loser's request is not latched; it stays pending and is re-evaluated in the next IDLE.
- Reset (any state, including mid-BUSY):
  - state ← IDLE, `prio` ← 0, counter ← 0, latched request ← OPNONE/0.
  - All outputs are 0 in the cycle after reset is sampled. No response or error is issued for an aborted transaction.

## Timing
- Request sampled in IDLE at edge N → `processor2cache.valid`=1 from cycle N+1.
- Response at cycle M → `resp_valid` in cycle M. `processor2cache.valid` drops at M+1, which is always one IDLE cycle.
- The mandatory IDLE gap lets the requester drop `req_valid` after seeing `resp_valid`, so a stale request is never re-granted.
- Minimum back-to-back period: 1 (IDLE) + cache latency cycles.
- `resp_valid` and `resp_err` are mutually exclusive and never both set for one port.

## Structure
- Add to `cache_parameters`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} type_arb_state_e`
  - `ARB_NPORTS = 2`
- Add a `type_arb_req_s` struct (op, address, data) to the same package; it is used for both the latched request and the per-port inputs.
- Add one sub-module, `rr_picker`:
  - inputs: 2-bit request, `prio`
  - outputs: one-hot grant, index
  - purely combinational

## Test plan
- Single read, port 0: `req_op`=OPREAD, addr 0x0000_0010; cache responds after 3 BUSY cycles with 0x2021_EE83 → `resp_valid`=2'b01, `resp_data`=0x2021_EE83, one IDLE cycle, `processor2cache.valid` low.
- Simultaneous requests: port 0 write (0x1, 0xDEAD_BEEF) and port 1 read (0x40) after reset.
  - Port 0 is served first; port 1 is served immediately after.
  - Grants alternate 0,1,0,1 over four rounds with both ports held valid.
- Payload stability: port 1 changes `req_addr` from 0x80 to 0xC0 mid-BUSY → cache sees 0x80 throughout.
- Timeout: TIMEOUT_CYCLES=8, cache never responds → `resp_err`=2'b10 in the 8th BUSY cycle, no `resp_valid`, return to IDLE, `prio`=0.
- Reset mid-BUSY: assert `reset` for one cycle during a port 0 read → next cycle all outputs 0, state IDLE; port 1 requesting alone is then granted normally.
- `cache2processor.ready`=0 with a pending request → the arbiter stays in IDLE; grant occurs in the cycle after ready rises.
